// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Two-write / two-read register file for the datapath.
//   - Write port 0 is the ALU writeback and write port 1 is the load return.
//     When both ports target the same register, port 1 wins.
//   - Optional hardwired zero register (ZERO_REG) and optional same-cycle
//     write-through bypass to the read ports (BYPASS).
//   - A per-register pending bit (scoreboard) lets decode stall on
//     outstanding loads. A write clears the bit. pend_set sets it, and the
//     set wins when both hit the same register in one cycle.
//   - After reset the array is zeroed by a sequential sweep, one register per
//     clock (CLEAR). ready rises once the sweep completes (RUN).
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   ready               array cleared and accepting writes
//   ra, rb / A, B       combinational read ports (address / data)
//   a_pend, b_pend      pending bit of ra / rb
//   we0, rw0, data0     write port 0 (ALU writeback)
//   we1, rw1, data1     write port 1 (load return, higher priority)
//   pend_set, pend_addr mark a register pending at the next edge
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              ready,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              a_pend,
    output logic              b_pend,
    input  logic              we0,
    input  logic [ADDR_W-1:0] rw0,
    input  logic [DATA_W-1:0] data0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [DATA_W-1:0] data1,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   sweep;
    logic [DATA_W-1:0]  regs [NREGS];
    logic [NREGS-1:0]   pending;

    logic               run;
    logic               wr0;
    logic               wr1;
    logic               ps;
    logic [ADDR_W-1:0]  raddr [2];
    logic [DATA_W-1:0]  rdata [2];
    logic               rpend [2];

    // Address maps to a real, writable register: in range and not the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = (32'(a) < NREGS);
        if (ZERO_REG != 0 && a == '0)
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    assign run = (state == RUN);
    assign wr0 = run && we0 && addr_ok(rw0);
    assign wr1 = run && we1 && addr_ok(rw1);
    assign ps  = run && pend_set && addr_ok(pend_addr);

    // Control: the sweep runs once per reset. ready is registered so that it
    // drops asynchronously with reset and rises on the edge that clears the
    // last register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            sweep <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (sweep == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
                RUN: ready <= 1'b1;
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset term. It is zeroed by the CLEAR
    // sweep, so it can map onto plain RAM or flop arrays without a reset net.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            regs[sweep] <= '0;
        end else begin
            if (wr0)
                regs[idx(rw0)] <= data0;
            // Port 1 is assigned last, so it wins on an address collision.
            if (wr1)
                regs[idx(rw1)] <= data1;
        end
    end

    // Scoreboard: a retiring write clears the bit. A new load issued in the
    // same cycle sets it again, because the set is assigned after the clears.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (state == CLEAR) begin
            pending <= '0;
        end else begin
            if (wr0)
                pending[idx(rw0)] <= 1'b0;
            if (wr1)
                pending[idx(rw1)] <= 1'b0;
            if (ps)
                pending[idx(pend_addr)] <= 1'b1;
        end
    end

    assign raddr[0] = ra;
    assign raddr[1] = rb;

    // NOTE: every output of this block gets a default before any condition,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rpend[p] = 1'b0;
            if (run && addr_ok(raddr[p])) begin
                rdata[p] = regs[idx(raddr[p])];
                rpend[p] = pending[idx(raddr[p])];
                if (BYPASS != 0) begin
                    // A forwarded value is the post-edge state. The write
                    // retires the old pend bit, and only a same-cycle set on
                    // this register keeps it pending.
                    if (wr1 && rw1 == raddr[p]) begin
                        rdata[p] = data1;
                        rpend[p] = ps && (pend_addr == raddr[p]);
                    end else if (wr0 && rw0 == raddr[p]) begin
                        rdata[p] = data0;
                        rpend[p] = ps && (pend_addr == raddr[p]);
                    end
                end
            end
        end
    end

    assign A      = rdata[0];
    assign B      = rdata[1];
    assign a_pend = rpend[0];
    assign b_pend = rpend[1];

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Drives two regfile_mp instances from the same stimulus: one with bypass,
//   one without. Their outputs are compared against a behavioural model of the
//   register file (array contents, pending flags, clear-sweep cycle count).
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int NREGS    = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 1;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] ra, rb, rw0, rw1, pend_addr;
    logic [DATA_W-1:0] data0, data1;
    logic              we0, we1, pend_set;

    logic              ready_bp, ready_nb;
    logic [DATA_W-1:0] a_bp, b_bp, a_nb, b_nb;
    logic              ap_bp, bp_bp, ap_nb, bp_nb;

    regfile_mp #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W),
                 .ZERO_REG(ZERO_REG), .BYPASS(1)) u_dut_bp (
        .clock(clock), .reset(reset), .ready(ready_bp),
        .ra(ra), .rb(rb), .A(a_bp), .B(b_bp), .a_pend(ap_bp), .b_pend(bp_bp),
        .we0(we0), .rw0(rw0), .data0(data0),
        .we1(we1), .rw1(rw1), .data1(data1),
        .pend_set(pend_set), .pend_addr(pend_addr)
    );

    regfile_mp #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W),
                 .ZERO_REG(ZERO_REG), .BYPASS(0)) u_dut_nb (
        .clock(clock), .reset(reset), .ready(ready_nb),
        .ra(ra), .rb(rb), .A(a_nb), .B(b_nb), .a_pend(ap_nb), .b_pend(bp_nb),
        .we0(we0), .rw0(rw0), .data0(data0),
        .we1(we1), .rw1(rw1), .data1(data1),
        .pend_set(pend_set), .pend_addr(pend_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mem_m  [NREGS];
    bit                pend_m [NREGS];
    bit                ready_m;
    int                clr_cnt;

    function automatic bit ok(input int a);
        return (a < NREGS) && !(ZERO_REG != 0 && a == 0);
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input int a, input bit bp);
        if (!ready_m || !ok(a)) return '0;
        if (bp && we1 && int'(rw1) == a) return data1;
        if (bp && we0 && int'(rw0) == a) return data0;
        return mem_m[a];
    endfunction

    function automatic logic exp_pd(input int a, input bit bp);
        if (!ready_m || !ok(a)) return 1'b0;
        if (bp && ((we1 && int'(rw1) == a) || (we0 && int'(rw0) == a)))
            return pend_set && int'(pend_addr) == a;
        return pend_m[a];
    endfunction

    task automatic model_reset();
        ready_m = 0;
        clr_cnt = 0;
        for (int i = 0; i < NREGS; i++) begin
            mem_m[i]  = '0;
            pend_m[i] = 0;
        end
    endtask

    task automatic model_edge();
        if (reset) return;
        if (!ready_m) begin
            clr_cnt++;
            if (clr_cnt == NREGS) ready_m = 1;
            return;
        end
        if (we0 && ok(int'(rw0))) begin
            mem_m[rw0]  = data0;
            pend_m[rw0] = 0;
        end
        if (we1 && ok(int'(rw1))) begin
            mem_m[rw1]  = data1;
            pend_m[rw1] = 0;
        end
        if (pend_set && ok(int'(pend_addr))) pend_m[pend_addr] = 1;
    endtask

    // Called at posedge+1 with inputs already set: compare mid-cycle, then
    // advance through the edge and update the model.
    task automatic step();
        #4;
        check("ready_bp", 32'(ready_bp), 32'(ready_m));
        check("ready_nb", 32'(ready_nb), 32'(ready_m));
        check("A_bp", a_bp, exp_rd(int'(ra), 1));
        check("B_bp", b_bp, exp_rd(int'(rb), 1));
        check("apend_bp", 32'(ap_bp), 32'(exp_pd(int'(ra), 1)));
        check("bpend_bp", 32'(bp_bp), 32'(exp_pd(int'(rb), 1)));
        check("A_nb", a_nb, exp_rd(int'(ra), 0));
        check("B_nb", b_nb, exp_rd(int'(rb), 0));
        check("apend_nb", 32'(ap_nb), 32'(exp_pd(int'(ra), 0)));
        check("bpend_nb", 32'(bp_nb), 32'(exp_pd(int'(rb), 0)));
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; pend_set = 0;
        rw0 = '0; rw1 = '0; pend_addr = '0;
        data0 = '0; data1 = '0;
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        // Bias half the traffic onto a few registers to force collisions.
        if ($urandom_range(0, 1) == 0) return ADDR_W'($urandom_range(0, 7));
        return ADDR_W'($urandom_range(0, NREGS - 1));
    endfunction

    initial begin
        reset = 1'b1;
        ra = '0; rb = '0;
        idle();
        model_reset();
        @(posedge clock); #1;
        step();
        step();

        // Sweep: writes during CLEAR must be ignored.
        reset = 1'b0;
        we0 = 1; rw0 = 5; data0 = 32'hDEADBEEF;
        pend_set = 1; pend_addr = 5;
        ra = 5; rb = 5;
        for (int i = 0; i < NREGS; i++) begin
            #2 check("ready_in_clear", 32'(ready_bp), 32'(0));
            step();
        end
        idle();
        #2 check("ready_after_sweep", 32'(ready_bp), 32'(1));
        check("r5_after_clear", a_bp, 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            ra = ADDR_W'(i); rb = ADDR_W'(NREGS - 1 - i);
            step();
        end

        // Dual write to r3: port 1 wins, bypass shows it the same cycle.
        we0 = 1; rw0 = 3; data0 = 32'h11111111;
        we1 = 1; rw1 = 3; data1 = 32'h22222222;
        ra = 3;
        #2 check("r3_bypass", a_bp, 32'h22222222);
        check("r3_nobypass_old", a_nb, 32'h0);
        step();
        idle();
        #2 check("r3_after", a_nb, 32'h22222222);
        step();

        // No-bypass timing on r7.
        we0 = 1; rw0 = 7; data0 = 32'h12345678; ra = 7;
        #2 check("r7_same_cycle_nb", a_nb, 32'h0);
        step();
        idle();
        #2 check("r7_next_cycle_nb", a_nb, 32'h12345678);
        step();

        // Zero register ignores writes and pend_set.
        we0 = 1; rw0 = 0; data0 = 32'hFFFFFFFF; pend_set = 1; pend_addr = 0;
        ra = 0;
        step();
        idle();
        #2 check("r0_data", a_bp, 32'h0);
        check("r0_pend", 32'(ap_bp), 32'(0));
        step();

        // Scoreboard on r9.
        rb = 9; pend_set = 1; pend_addr = 9;
        step();
        idle();
        #2 check("r9_pend_set", 32'(bp_nb), 32'(1));
        step();
        we1 = 1; rw1 = 9; data1 = 32'h0000CAFE;
        step();
        idle();
        #2 check("r9_pend_cleared", 32'(bp_nb), 32'(0));
        step();
        pend_set = 1; pend_addr = 9; we0 = 1; rw0 = 9; data0 = 32'h0000BEEF;
        #2 check("r9_set_wins_bypass", 32'(bp_bp), 32'(1));
        step();
        idle();
        #2 check("r9_set_wins", 32'(bp_nb), 32'(1));
        step();

        // Randomised traffic.
        for (int n = 0; n < 1500; n++) begin
            we0 = ($urandom_range(0, 1) == 1);
            we1 = ($urandom_range(0, 2) == 0);
            pend_set = ($urandom_range(0, 3) == 0);
            rw0 = rnd_addr(); rw1 = rnd_addr(); pend_addr = rnd_addr();
            data0 = $urandom; data1 = $urandom;
            ra = rnd_addr(); rb = rnd_addr();
            step();
        end
        idle();

        // Reset in RUN, then again mid-CLEAR at sweep count 10.
        we0 = 1; rw0 = 4; data0 = 32'hA5A5A5A5;
        step();
        idle();
        pend_set = 1; pend_addr = 4;
        step();
        idle();
        reset = 1'b1;
        model_reset();
        #1 check("ready_drop_run", 32'(ready_bp), 32'(0));
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        model_reset();
        #1 check("ready_drop_clear", 32'(ready_nb), 32'(0));
        step();
        reset = 1'b0;
        we1 = 1; rw1 = 4; data1 = 32'h5A5A5A5A;
        for (int i = 0; i < NREGS; i++) begin
            ra = 4; rb = 4;
            step();
        end
        idle();
        #2 check("ready_after_resweep", 32'(ready_bp), 32'(1));
        check("r4_after_reset", a_nb, 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            ra = ADDR_W'(i); rb = ADDR_W'(i);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised, two-write/two-read register file with write-through bypass, optional hardwired zero register, a per-register pending (scoreboard) bit and a sequential clear sweep after reset. It replaces the single-write register file in the datapath and serves the decode stage (two source operands) and writeback (ALU result port plus load-return port). The scoreboard lets decode stall on registers with an outstanding load.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers (≥2)
- ADDR_W, 5, address width; NREGS ≤ 2^ADDR_W
- ZERO_REG, 1, if 1, register 0 reads 0, ignores writes and is never pending
- BYPASS, 1, if 1, same-cycle write data is forwarded to read ports

Ports:
- clock  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-high
- ready  out  1  array cleared and accepting writes
- ra  in  ADDR_W  read address, port A
- rb  in  ADDR_W  read address, port B
- A  out  DATA_W  read data, port A
- B  out  DATA_W  read data, port B
- a_pend  out  1  pending bit of ra
- b_pend  out  1  pending bit of rb
- we0  in  1  write enable, port 0 (ALU writeback)
- rw0  in  ADDR_W  write address, port 0
- data0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (load return)
- rw1  in  ADDR_W  write address, port 1
- data1  in  DATA_W  write data, port 1
- pend_set  in  1  mark register pend_addr pending
- pend_addr  in  ADDR_W  register to mark

## Operation
- States: CLEAR, RUN. reset asserted → CLEAR, sweep counter = 0, all pending bits = 0, ready = 0 (immediately, asynchronously).
- CLEAR: each rising edge writes 0 to regs[counter], counter += 1; on the edge clearing NREGS−1, go to RUN. we0/we1/pend_set ignored; A, B read 0; a_pend, b_pend = 0.
- RUN: ready = 1. On each edge: we0 writes data0 to rw0, we1 writes data1 to rw1. Same address on both ports: port 1 wins.
- Pending: a write on either port clears pending[rw]; pend_set sets pending[pend_addr]. pend_set and a write to the same register in one cycle: set wins (new load issued after old write retires).
- ZERO_REG=1: writes and pend_set to address 0 dropped; A/B = 0 and a_pend/b_pend = 0 when address is 0.
- Addresses ≥ NREGS: writes dropped, reads return 0, pending reads 0.
- Reads combinational from the array. BYPASS=1: if an enabled write in the current cycle targets ra (rb), A (B) returns that write's data (port 1 priority) and a_pend (b_pend) = 0 unless pend_set targets the same register this cycle. BYPASS=0: reads return pre-edge contents.

## Timing
- Read latency 0 (combinational); write visible on A/B the cycle after the edge (same cycle with BYPASS=1).
- ready rises on the NREGS-th rising edge after reset deasserts; exactly NREGS cycles in CLEAR.
- reset mid-RUN or mid-CLEAR: ready drops at once, counter restarts at 0, full sweep repeats; all contents lost.
- pend_set takes effect at the edge; a_pend reflects it the following cycle.
- No back-pressure: writes in RUN always complete in one cycle.

## Test plan
- Reset then hold reset low: ready = 0 for 32 edges, 1 after the 32nd; every register reads 0; we0 to r5 = 0xDEADBEEF during CLEAR leaves r5 = 0.
- RUN: we0 rw0=3 data0=0x11111111 and we1 rw1=3 data1=0x22222222 same cycle → r3 = 0x22222222; with BYPASS=1, ra=3 that cycle shows A = 0x22222222.
- BYPASS=0: write r7 = 0x12345678, ra=7 same cycle → A = old value (0), next cycle 0x12345678.
- ZERO_REG=1: we0 rw0=0 data0=0xFFFFFFFF and pend_set addr 0 → A at ra=0 stays 0, a_pend = 0.
- Scoreboard: pend_set r9 → b_pend (rb=9) = 1 next cycle; we1 rw1=9 → b_pend = 0 after edge; pend_set r9 and we0 rw0=9 same cycle → b_pend = 1.
- Reset asserted at sweep count 10 after r4 written = 0xA5A5A5A5 in prior RUN: ready 0 immediately, 32 fresh CLEAR cycles, r4 reads 0, all pending 0.
